axi4_mem_slave_ctrl: RTL and testbench
======================================

// Module: axi4_mem_slave_ctrl
// PURPOSE
//  AXI4 slave front-end for the single-port axi4_memory block. Accepts AXI4 write (AW/W/B) and
//  read (AR/R) bursts, arbitrates them onto the one mem_* port, and serialises beats into
//  word accesses. Sits directly upstream of axi4_memory; mem_* outputs connect 1:1 to its ports.
// PARAMETERS
//  DATA_WIDTH      32            data bus width; one beat = one memory word
//  ADDR_WIDTH      10            memory word-address width
//  DEPTH           1024          memory words; word index >= DEPTH is out of range
//  AXI_ADDR_WIDTH  ADDR_WIDTH+2  AXI byte-address width
//  ID_WIDTH        4             AXI ID width
// PORTS
//  clk         in   1               clock
//  rst_n       in   1               synchronous active-low reset
//  awid/arid   in   ID_WIDTH        transaction IDs
//  awaddr/araddr in AXI_ADDR_WIDTH  byte start address; bits [1:0] ignored
//  awlen/arlen in   8               beats-1
//  awburst/arburst in 2             2'b00 FIXED, 2'b01 INCR, others -> SLVERR
//  awvalid/arvalid in 1; awready/arready out 1   address handshakes
//  wdata in DATA_WIDTH; wstrb in DATA_WIDTH/8; wlast in 1; wvalid in 1; wready out 1
//  bid out ID_WIDTH; bresp out 2; bvalid out 1; bready in 1
//  rid out ID_WIDTH; rdata out DATA_WIDTH; rresp out 2; rlast out 1; rvalid out 1; rready in 1
//  mem_en/mem_we out 1; mem_addr out ADDR_WIDTH; mem_wdata out DATA_WIDTH; mem_rdata in DATA_WIDTH
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state IDLE; all ready/valid, mem_en, mem_we, bresp, rresp, rlast,
//   rdata, mem_addr, mem_wdata = 0; last_grant=READ (write wins first). Mid-burst reset aborts, no B/R.
//  Single FSM: IDLE, WR_DATA, WR_RESP, RD_ISSUE, RD_CAPT, RD_DATA. Read/write never overlap.
//  IDLE: awready/arready driven comb.: grant write if awvalid & (!arvalid | last_grant==READ), else
//   read if arvalid. Only granted ready is high. On handshake latch id, len, burst, word index
//   = addr[AXI_ADDR_WIDTH-1:2] (ADDR_WIDTH+1 bits internal, no wrap); clear beat cnt, err flag.
//  WR_DATA: wready=1. On wvalid&wready: mem_en=1 same cycle (comb.); mem_we=1 only if index<DEPTH,
//   wstrb all-ones, burst legal; mem_addr=index, mem_wdata=wdata. Else beat dropped, err flag set.
//   wlast != (cnt==len) also sets err. INCR: index+1 per beat; FIXED: hold. After beat cnt==len -> WR_RESP.
//  WR_RESP: bvalid=1, bid=latched id, bresp=err?2'b10:2'b00; hold stable until bready -> IDLE.
//  RD_ISSUE (1 cycle): mem_en=1, mem_we=0, mem_addr=index if beat legal, else mem_en=0 -> RD_CAPT.
//  RD_CAPT (1 cycle): rdata<=legal?mem_rdata:0; rresp<=legal?00:10; rlast<=(cnt==len) -> RD_DATA.
//  RD_DATA: rvalid=1, rid/rdata/rresp/rlast stable until rready. On rready: rlast -> IDLE, else
//   advance index (INCR/FIXED), cnt+1 -> RD_ISSUE. Min 3 cycles/read beat, 1 cycle/write beat.
//  Legal beat: index<DEPTH and burst in {FIXED,INCR}. Illegal beats never write memory.
//  last_grant updated on every AW/AR acceptance. mem_* idle values: mem_en=0, mem_we=0.
// TESTING
//  1 Write len0 addr 0x010 data 0xDEADBEEF, then read addr 0x010 -> rdata 0xDEADBEEF, rresp 00,
//    rlast 1, mem write seen at mem_addr 4, bresp 00.
//  2 INCR len3 write addr 0x100 data 1,2,3,4; read back with rready toggling each cycle ->
//    data 1..4 in order, rvalid/rdata stable while stalled, rlast only on beat 4.
//  3 awvalid&arvalid same cycle after reset -> write granted; repeat -> read granted next.
//  4 Write wstrb 4'b0011 data 0xFFFFFFFF to word 5 (holding 0) -> no mem_we, bresp 10, word 5 still 0.
//  5 INCR len3 read at byte 0xFF8 (word 1022), DEPTH=1024 -> beats 1,2 rresp 00; beats 3,4
//    rresp 10 rdata 0; no mem_en for beats 3,4.
//  6 rst_n low during WR_DATA beat 2 of 4 -> next cycle all outputs 0, no bvalid; a new
//    len0 write completes with bresp 00.

Source files
------------

// File: rtl/axi4_mem_slave_ctrl.sv
// rtl/axi4_mem_slave_ctrl.sv - AXI4 slave front-end serialising bursts onto a single-port memory
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   aw*/w*/b*                      AXI4 write address, write data and write response channels
//   ar*/r*                         AXI4 read address and read data channels
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata
//                                  single-port memory, 1-cycle read latency
module axi4_mem_slave_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int DEPTH          = 1024,
    parameter int AXI_ADDR_WIDTH = ADDR_WIDTH + 2,
    parameter int ID_WIDTH       = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ID_WIDTH-1:0]       awid,
    input  logic [AXI_ADDR_WIDTH-1:0] awaddr,
    input  logic [7:0]                awlen,
    input  logic [1:0]                awburst,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
    input  logic                      wlast,
    input  logic                      wvalid,
    output logic                      wready,
    output logic [ID_WIDTH-1:0]       bid,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    input  logic [ID_WIDTH-1:0]       arid,
    input  logic [AXI_ADDR_WIDTH-1:0] araddr,
    input  logic [7:0]                arlen,
    input  logic [1:0]                arburst,
    input  logic                      arvalid,
    output logic                      arready,
    output logic [ID_WIDTH-1:0]       rid,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                rresp,
    output logic                      rlast,
    output logic                      rvalid,
    input  logic                      rready,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WR_DATA  = 3'd1;
    localparam logic [2:0] S_WR_RESP  = 3'd2;
    localparam logic [2:0] S_RD_ISSUE = 3'd3;
    localparam logic [2:0] S_RD_CAPT  = 3'd4;
    localparam logic [2:0] S_RD_DATA  = 3'd5;

    localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LP_ONE   = (ADDR_WIDTH+1)'(1);

    logic [2:0]            r_state;
    logic                  r_last_grant_rd;
    logic [ID_WIDTH-1:0]   r_id;
    logic [7:0]            r_len;
    logic [7:0]            r_cnt;
    logic [1:0]            r_burst;
    // One extra bit so an INCR burst running past the top is seen as out of range, not wrapped.
    logic [ADDR_WIDTH:0]   r_idx;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;
    logic                  r_rlast;

    logic                  w_grant_wr;
    logic                  w_aw_hs;
    logic                  w_ar_hs;
    logic                  w_legal;
    logic                  w_last_beat;
    logic                  w_w_hs;
    logic                  w_wr_ok;
    logic [ADDR_WIDTH:0]   w_next_idx;
    logic                  w_unused_addr_lsbs;

    // Write wins unless the previous grant was also a write and a read is waiting.
    assign w_grant_wr  = awvalid & (~arvalid | r_last_grant_rd);
    assign w_aw_hs     = (r_state == S_IDLE) & w_grant_wr;
    assign w_ar_hs     = (r_state == S_IDLE) & ~w_grant_wr & arvalid;
    assign w_legal     = (r_idx < LP_DEPTH) & ~r_burst[1];
    assign w_last_beat = (r_cnt == r_len);
    assign w_w_hs      = (r_state == S_WR_DATA) & wvalid;
    assign w_wr_ok     = w_legal & (&wstrb);
    assign w_next_idx  = (r_burst == 2'b01) ? r_idx + LP_ONE : r_idx;

    assign w_unused_addr_lsbs = ^{awaddr[1:0], araddr[1:0]};

    always_comb begin
        awready   = w_aw_hs;
        arready   = w_ar_hs;
        wready    = (r_state == S_WR_DATA);
        bvalid    = (r_state == S_WR_RESP);
        bid       = r_id;
        bresp     = r_err ? 2'b10 : 2'b00;
        rvalid    = (r_state == S_RD_DATA);
        rid       = r_id;
        rdata     = r_rdata;
        rresp     = r_rresp;
        rlast     = r_rlast;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_w_hs) begin
            // Every accepted write beat enables the memory; only clean beats actually write.
            mem_en    = 1'b1;
            mem_we    = w_wr_ok;
            mem_addr  = r_idx[ADDR_WIDTH-1:0];
            mem_wdata = wdata;
        end else if ((r_state == S_RD_ISSUE) && w_legal) begin
            mem_en   = 1'b1;
            mem_addr = r_idx[ADDR_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_last_grant_rd <= 1'b1;
            r_id            <= '0;
            r_len           <= '0;
            r_cnt           <= '0;
            r_burst         <= '0;
            r_idx           <= '0;
            r_err           <= 1'b0;
            r_rdata         <= '0;
            r_rresp         <= '0;
            r_rlast         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_aw_hs) begin
                        r_id            <= awid;
                        r_len           <= awlen;
                        r_burst         <= awburst;
                        r_idx           <= (ADDR_WIDTH+1)'(awaddr[AXI_ADDR_WIDTH-1:2]);
                        r_cnt           <= '0;
                        r_err           <= 1'b0;
                        r_last_grant_rd <= 1'b0;
                        r_state         <= S_WR_DATA;
                    end else if (w_ar_hs) begin
                        r_id            <= arid;
                        r_len           <= arlen;
                        r_burst         <= arburst;
                        r_idx           <= (ADDR_WIDTH+1)'(araddr[AXI_ADDR_WIDTH-1:2]);
                        r_cnt           <= '0;
                        r_err           <= 1'b0;
                        r_last_grant_rd <= 1'b1;
                        r_state         <= S_RD_ISSUE;
                    end
                end
                S_WR_DATA: begin
                    if (wvalid) begin
                        if (!w_wr_ok || (wlast != w_last_beat)) begin
                            r_err <= 1'b1;
                        end
                        r_idx <= w_next_idx;
                        r_cnt <= r_cnt + 8'd1;
                        if (w_last_beat) begin
                            r_state <= S_WR_RESP;
                        end
                    end
                end
                S_WR_RESP: begin
                    if (bready) begin
                        r_state <= S_IDLE;
                    end
                end
                S_RD_ISSUE: begin
                    r_state <= S_RD_CAPT;
                end
                S_RD_CAPT: begin
                    // mem_rdata is valid here, one cycle after the RD_ISSUE enable.
                    r_rdata <= w_legal ? mem_rdata : '0;
                    r_rresp <= w_legal ? 2'b00 : 2'b10;
                    r_rlast <= w_last_beat;
                    r_state <= S_RD_DATA;
                end
                S_RD_DATA: begin
                    if (rready) begin
                        if (r_rlast) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_idx   <= w_next_idx;
                            r_cnt   <= r_cnt + 8'd1;
                            r_state <= S_RD_ISSUE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_mem_slave_ctrl.sv
// tb/tb_axi4_mem_slave_ctrl.sv - randomized self-checking bench for axi4_mem_slave_ctrl
module tb_axi4_mem_slave_ctrl;

    logic        clk;
    logic        rst_n;
    logic [3:0]  awid, arid, bid, rid;
    logic [11:0] awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, arvalid, arready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic        bvalid, bready;
    logic        rlast, rvalid, rready;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    axi4_mem_slave_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port memory with one cycle of read latency.
    logic [31:0] tmem [0:1023];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) tmem[mem_addr] <= mem_wdata;
            else        mem_rdata      <= tmem[mem_addr];
        end
    end

    // Reference model state: memory image plus expected event queues.
    logic [31:0] ref_mem [0:1023];
    logic [42:0] exp_w[$];   // {should_write, addr, data} per accepted write beat
    logic [9:0]  exp_mr[$];  // addresses of legal read beats
    logic [38:0] exp_r[$];   // {id, data, resp, last}
    logic [5:0]  exp_b[$];   // {id, resp}

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] wbuf [0:255];
    logic [31:0] cap_data [0:255];
    logic [1:0]  cap_resp [0:255];
    logic        cap_last [0:255];
    int          cap_n;
    logic [1:0]  last_bresp;
    logic [9:0]  last_wr_addr;
    int          n_mem_rd = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: handshake not seen within cycle bound", name);
    endtask

    task automatic rst_check(input string tag);
        chk({tag, "_ctrl"}, {awready, arready, wready, bvalid, bresp, bid, rvalid, rresp, rlast,
                             mem_en, mem_we, mem_addr}, 64'd0);
        chk({tag, "_data"}, {rdata, mem_wdata}, 64'd0);
    endtask

    // Compare process: runs every cycle after inputs and combinational outputs have settled.
    logic       tb_lg_rd;
    logic       p_bstall, p_rstall;
    logic [5:0] p_b;
    logic [38:0] p_r;
    always begin
        logic [1:0]  eg;
        logic [42:0] ew;
        @(negedge clk);
        #2;
        if (!rst_n) begin
            tb_lg_rd = 1'b1;
            p_bstall = 1'b0;
            p_rstall = 1'b0;
        end else begin
            if (awready || arready) begin
                if (awvalid && (!arvalid || tb_lg_rd)) eg = 2'b10;
                else if (arvalid)                      eg = 2'b01;
                else                                   eg = 2'b00;
                chk("grant", {awready, arready}, eg);
            end
            if (awvalid && awready) tb_lg_rd = 1'b0;
            else if (arvalid && arready) tb_lg_rd = 1'b1;

            if (wvalid && wready) begin
                if (exp_w.size() == 0) chk("mem_wr_unexpected", 1, 0);
                else begin
                    ew = exp_w.pop_front();
                    if (ew[42]) begin
                        chk("mem_wr", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, ew});
                        last_wr_addr = mem_addr;
                    end else begin
                        chk("mem_wr_drop", {mem_en, mem_we}, 2'b10);
                    end
                end
            end else begin
                if (mem_we) chk("mem_we_outside_beat", 1, 0);
                if (mem_en) begin
                    n_mem_rd++;
                    if (exp_mr.size() == 0) chk("mem_rd_unexpected", {mem_en, mem_addr}, 0);
                    else chk("mem_rd", {mem_we, mem_addr}, {1'b0, exp_mr.pop_front()});
                end
            end

            if (p_bstall) chk("b_stable", {bvalid, bid, bresp}, {1'b1, p_b});
            if (p_rstall) chk("r_stable", {rvalid, rid, rdata, rresp, rlast}, {1'b1, p_r});
            if (bvalid && bready) begin
                if (exp_b.size() == 0) chk("b_unexpected", {bid, bresp}, 0);
                else chk("b_resp", {bid, bresp}, exp_b.pop_front());
            end
            if (rvalid && rready) begin
                if (exp_r.size() == 0) chk("r_unexpected", {rid, rdata, rresp, rlast}, 0);
                else chk("r_beat", {rid, rdata, rresp, rlast}, exp_r.pop_front());
            end
            p_bstall = bvalid && !bready;
            p_b      = {bid, bresp};
            p_rstall = rvalid && !rready;
            p_r      = {rid, rdata, rresp, rlast};
        end
    end

    // abort_at >= 0 pulses reset in place of that beat.
    task automatic axi_write(input logic [3:0] id, input logic [11:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [3:0] strb, input bit bad_last,
                             input int abort_at);
        logic [10:0] idx;
        bit          err;
        int          t;
        err = bad_last;
        for (int b = 0; b <= int'(len); b++) begin
            if (abort_at >= 0 && b >= abort_at) break;
            idx = 11'(addr[11:2]) + ((burst == 2'b01) ? 11'(b) : 11'd0);
            if (idx < 11'd1024 && burst < 2'd2 && strb == 4'hF) begin
                exp_w.push_back({1'b1, idx[9:0], wbuf[b]});
                ref_mem[idx[9:0]] = wbuf[b];
            end else begin
                exp_w.push_back(43'd0);
                err = 1'b1;
            end
        end
        if (abort_at < 0) exp_b.push_back({id, err ? 2'b10 : 2'b00});

        @(negedge clk);
        awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
        t = 0;
        #1;
        while (!awready) begin
            @(negedge clk); #1; t++;
            if (t > 400) begin tmo("aw"); awvalid = 1'b0; return; end
        end
        @(negedge clk);
        awvalid = 1'b0;

        for (int b = 0; b <= int'(len); b++) begin
            if (b == abort_at) begin
                wvalid = 1'b0;
                rst_n  = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                #2;
                rst_check("mid_burst_reset");
                return;
            end
            if (abort_at < 0 && b > 0 && $urandom_range(3) == 0) begin
                wvalid = 1'b0;
                @(negedge clk);
            end
            wdata = wbuf[b]; wstrb = strb; wlast = (b == int'(len)) ^ bad_last; wvalid = 1'b1;
            t = 0;
            #1;
            while (!wready) begin
                @(negedge clk); #1; t++;
                if (t > 400) begin tmo("w"); wvalid = 1'b0; return; end
            end
            @(negedge clk);
        end
        wvalid = 1'b0;
        wlast  = 1'b0;

        t = 0;
        forever begin
            bready = ($urandom_range(2) != 0);
            #1;
            if (bvalid && bready) begin last_bresp = bresp; @(negedge clk); break; end
            @(negedge clk); t++;
            if (t > 400) begin tmo("b"); break; end
        end
        bready = 1'b0;
    endtask

    // mode: 0 rready held high, 1 rready toggling each cycle, 2 random rready
    task automatic axi_read(input logic [3:0] id, input logic [11:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input int mode);
        logic [10:0] idx;
        bit          legal, done, tog;
        int          t;
        for (int b = 0; b <= int'(len); b++) begin
            idx   = 11'(addr[11:2]) + ((burst == 2'b01) ? 11'(b) : 11'd0);
            legal = (idx < 11'd1024) && (burst < 2'd2);
            if (legal) exp_mr.push_back(idx[9:0]);
            exp_r.push_back({id, legal ? ref_mem[idx[9:0]] : 32'd0, legal ? 2'b00 : 2'b10,
                             b == int'(len)});
        end

        @(negedge clk);
        arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
        t = 0;
        #1;
        while (!arready) begin
            @(negedge clk); #1; t++;
            if (t > 400) begin tmo("ar"); arvalid = 1'b0; return; end
        end
        @(negedge clk);
        arvalid = 1'b0;

        cap_n = 0; done = 1'b0; tog = 1'b0; t = 0;
        while (!done) begin
            tog = ~tog;
            rready = (mode == 0) ? 1'b1 : (mode == 1) ? tog : ($urandom_range(2) != 0);
            #1;
            if (rvalid && rready) begin
                cap_data[cap_n] = rdata; cap_resp[cap_n] = rresp; cap_last[cap_n] = rlast;
                cap_n++;
                if (rlast || cap_n > int'(len)) done = 1'b1;
            end
            @(negedge clk); t++;
            if (t > 2000) begin tmo("r"); done = 1'b1; end
        end
        rready = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int          nbad;
        int          rd0;
        logic [9:0]  rw;
        logic [11:0] ra;
        logic [7:0]  rl;
        logic [1:0]  rb;
        logic [3:0]  rs;
        int          rr;

        for (int i = 0; i < 1024; i++) begin tmem[i] = 32'd0; ref_mem[i] = 32'd0; end
        rst_n = 1'b0;
        awid = 0; awaddr = 0; awlen = 0; awburst = 0; awvalid = 0;
        wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
        arid = 0; araddr = 0; arlen = 0; arburst = 0; arvalid = 0; rready = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #2;
        rst_check("reset");

        // Simultaneous requests after reset: write first, then the waiting read.
        wbuf[0] = 32'h1111_1111;
        fork
            axi_write(4'h1, 12'h200, 8'd0, 2'b01, 4'hF, 1'b0, -1);
            axi_read(4'h2, 12'h300, 8'd1, 2'b01, 0);
            begin @(negedge clk); #1; chk("t3_first_grant", {awready, arready}, 2'b10); end
        join
        // After a lone write, a simultaneous pair goes to the read.
        wbuf[0] = 32'h2222_2222;
        axi_write(4'h3, 12'h204, 8'd0, 2'b01, 4'hF, 1'b0, -1);
        wbuf[0] = 32'h3333_3333;
        fork
            axi_write(4'h4, 12'h208, 8'd0, 2'b01, 4'hF, 1'b0, -1);
            axi_read(4'h5, 12'h200, 8'd0, 2'b01, 2);
            begin @(negedge clk); #1; chk("t3_second_grant", {awready, arready}, 2'b01); end
        join
        chk("t3_read_data", cap_data[0], 32'h1111_1111);

        // Single-beat write then read back.
        wbuf[0] = 32'hDEAD_BEEF;
        axi_write(4'h6, 12'h010, 8'd0, 2'b01, 4'hF, 1'b0, -1);
        chk("t1_bresp", last_bresp, 2'b00);
        chk("t1_mem_addr", last_wr_addr, 10'd4);
        axi_read(4'h6, 12'h010, 8'd0, 2'b01, 0);
        chk("t1_rbeat", {cap_n, cap_data[0], cap_resp[0], cap_last[0]},
            {32'd1, 32'hDEAD_BEEF, 2'b00, 1'b1});

        // INCR len3 write, read back with rready toggling.
        for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
        axi_write(4'h7, 12'h100, 8'd3, 2'b01, 4'hF, 1'b0, -1);
        axi_read(4'h7, 12'h100, 8'd3, 2'b01, 1);
        for (int i = 0; i < 4; i++)
            chk("t2_beat", {cap_data[i], cap_resp[i], cap_last[i]}, {32'(i + 1), 2'b00, i == 3});

        // Partial strobe: beat dropped, SLVERR.
        wbuf[0] = 32'hFFFF_FFFF;
        axi_write(4'h8, 12'h014, 8'd0, 2'b01, 4'b0011, 1'b0, -1);
        chk("t4_bresp", last_bresp, 2'b10);
        chk("t4_word5", tmem[5], 32'd0);

        // Read burst running past the top of memory.
        wbuf[0] = 32'h0000_00A1; wbuf[1] = 32'h0000_00A2;
        axi_write(4'h9, 12'hFF8, 8'd1, 2'b01, 4'hF, 1'b0, -1);
        rd0 = n_mem_rd;
        axi_read(4'hA, 12'hFF8, 8'd3, 2'b01, 0);
        chk("t5_data01", {cap_data[0], cap_data[1]}, {32'h0000_00A1, 32'h0000_00A2});
        chk("t5_resp", {cap_resp[0], cap_resp[1], cap_resp[2], cap_resp[3], cap_data[2], cap_data[3]},
            {2'b00, 2'b00, 2'b10, 2'b10, 32'd0, 32'd0});
        chk("t5_mem_reads", n_mem_rd - rd0, 2);

        // Reset in the middle of a 4-beat write, then a clean write.
        for (int i = 0; i < 4; i++) wbuf[i] = 32'h5000_0000 + 32'(i);
        axi_write(4'hB, 12'h040, 8'd3, 2'b01, 4'hF, 1'b0, 1);
        wbuf[0] = 32'h6000_0006;
        last_bresp = 2'b11;
        axi_write(4'hC, 12'h044, 8'd0, 2'b01, 4'hF, 1'b0, -1);
        chk("t6_bresp", last_bresp, 2'b00);

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            rw = ($urandom_range(3) == 0) ? 10'(1016 + $urandom_range(7)) : 10'($urandom_range(1023));
            ra = {rw, 2'($urandom_range(3))};
            rl = 8'($urandom_range(7));
            rr = $urandom_range(9);
            rb = (rr < 2) ? 2'b00 : (rr < 8) ? 2'b01 : 2'(rr - 6);
            rs = ($urandom_range(6) == 0) ? 4'($urandom_range(15)) : 4'hF;
            for (int i = 0; i < 256; i++) wbuf[i] = $urandom;
            if ($urandom_range(1) == 0)
                axi_write(4'($urandom_range(15)), ra, rl, rb, rs, ($urandom_range(9) == 0), -1);
            else
                axi_read(4'($urandom_range(15)), ra, rl, rb, $urandom_range(2));
        end

        repeat (4) @(negedge clk);
        chk("left_exp_w", exp_w.size(), 0);
        chk("left_exp_mr", exp_mr.size(), 0);
        chk("left_exp_r", exp_r.size(), 0);
        chk("left_exp_b", exp_b.size(), 0);
        nbad = 0;
        for (int i = 0; i < 1024; i++) if (tmem[i] !== ref_mem[i]) nbad++;
        chk("final_mem_image", nbad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
